bcd_scan_display: RTL and testbench
===================================

// Module: bcd_scan_display
// PURPOSE
//  Multi-digit 7-segment scan driver downstream of the cnt BCD counter stages.
//  - Captures N BCD digits (plus decimal points) on a load strobe.
//  - Time-multiplexes the digits onto one shared segment bus and N active-low digit enables.
//  - Decodes each digit through decodDisplay.
//  - Inserts a dead interval between digits against ghosting, and blanks leading zeros.
// PARAMETERS
//  N_DIGITS  4      number of scanned digits, range 2..8; digit 0 is the least significant
//  SCAN_DIV  50000  clk cycles per digit slot (>= DEAD_CYC+2); 1 kHz/digit at 50 MHz
//  DEAD_CYC  8      cycles at the start of each slot with all enables off (0 = none)
//  BLANK_LZ  1      1 = blank leading zeros; the least significant digit is never blanked
// PORTS
//  clk        in   1          system clock, rising-edge
//  rst_n      in   1          asynchronous reset, active low
//  digits_in  in   4*N_DIGITS BCD digits; digit k is at [4k+3:4k]
//  dp_in      in   N_DIGITS   decimal point per digit, 1 = lit
//  load       in   1          1-cycle strobe: capture digits_in/dp_in
//  lamp_test  in   1          1 = all segments and the DP lit on every scanned digit
//  display    out  7          segment bus, decodDisplay encoding/polarity
//  dp         out  1          decimal point segment, 1 = lit
//  an         out  N_DIGITS   digit enables, active low, at most one low at any time
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - shadow digits = 0, shadow dp = 0, prescaler = 0, digit index = 0.
//   - an = all 1s, display = SEG_BLANK, dp = 0.
//   - Outputs stay in this state until the first slot's dead interval ends.
//  Capture:
//   - load=1 at edge t: shadow regs update at t; the new values are first visible from the next slot start.
//   - The digit currently being shown never changes mid-slot (no tearing).
//   - load held high recaptures every cycle; the last value before a slot start wins.
//  Prescaler:
//   - Counts 0..SCAN_DIV-1 and wraps to 0.
//   - On wrap, digit index advances 0,1,..,N_DIGITS-1,0 (ascending, wraps).
//  Slot timing (prescaler value p):
//   - p < DEAD_CYC: an = all 1s.
//   - p >= DEAD_CYC: an[idx] = 0, all other bits 1.
//   - display/dp are registered with the same timing as an, so segments never lead or trail their enable.
//   - Enable duty per digit = (SCAN_DIV-DEAD_CYC)/(N_DIGITS*SCAN_DIV).
//  Decode:
//   - Values 0..9 go through decodDisplay.
//   - Values 10..15 show SEG_DASH (decodDisplay output is overridden).
//   - A digit is a leading zero when it and every more-significant digit equal 0.
//   - With BLANK_LZ=1, a leading-zero digit shows SEG_BLANK with its an still driven, and its dp is still honoured.
//   - The LSD always shows, even when all digits are 0.
//  Lamp test:
//   - lamp_test=1 overrides decode, blanking and dp: display = SEG_ALL, dp = 1.
//   - Scan and dead intervals continue unchanged.
//   - Takes effect at the next registered output update (1 cycle).
//  Simultaneous events:
//   - load in the same cycle as a slot start: the new value is used for that slot, since capture and slot start share an edge and the decode reads the shadow value after update.
//   - rst_n asserted mid-slot: outputs go to their reset values immediately (async).
//   - rst_n released: scan restarts at digit 0, prescaler 0.
// STRUCTURE
//  Package bcd_disp_pkg holds:
//   - constants SEG_BLANK, SEG_DASH, SEG_ALL (7-bit, decodDisplay polarity);
//   - localparam functions clog2 for prescaler/index widths.
//  Sub-module: decodDisplay (existing) is instantiated once on the muxed digit.
//  Everything else (prescaler, index, shadow regs, leading-zero mask, output regs) stays in this block.
// TESTING (bench: N_DIGITS=4, SCAN_DIV=6, DEAD_CYC=2, BLANK_LZ=1)
//  1 Reset held, then released:
//    - while held: an=4'b1111, display=SEG_BLANK, dp=0;
//    - after release: cycles 0-1 an=1111, cycles 2-5 an=1110;
//    - the next slot has an=1101 at cycle 8.
//  2 load digits_in=16'h1234:
//    - digit 0 slot shows decode(4), digit 3 slot shows decode(1);
//    - the pattern repeats every 24 cycles;
//    - an never has two 0 bits (assertion).
//  3 digits_in=16'h0070, dp_in=4'b1000:
//    - digits 3 and 2 show SEG_BLANK (digit 3 with dp=1);
//    - digit 1 shows decode(7); digit 0 shows decode(0).
//    - digits_in=0: only digit 0 shows decode(0).
//  4 digits_in=16'h9AF0:
//    - digits 2 and 1 show SEG_DASH, digit 3 shows decode(9).
//    - lamp_test=1 mid-slot: next cycle display=SEG_ALL, dp=1; scan timing unchanged.
//  5 load 16'h1111 then 16'h2222 midway through the digit 1 slot:
//    - the digit 1 slot keeps decode(1) to its end;
//    - the digit 2 slot shows decode(2).
//  6 rst_n pulsed low for 1 cycle mid-slot of digit 2:
//    - an=1111 asynchronously; shadow = 0;
//    - scan resumes at digit 0 with a fresh dead interval.

Source files
------------

// File: rtl/bcd_scan_display_pkg.sv
// Shared constants and elaboration helpers for the multiplexed BCD display driver.
// Segment polarity is active low, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ALL   = 7'h00;

    // Width needed to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Digit capture / segment drive bundle between a digit source and the scan driver.
interface bcd_scan_display_if #(
    parameter int N_DIGITS = 4
) ();
    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  lamp_test;
    logic [6:0]            display;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;

    modport master (
        output digits_in, dp_in, load, lamp_test,
        input  display, dp, an
    );

    modport slave (
        input  digits_in, dp_in, load, lamp_test,
        output display, dp, an
    );
endinterface

// File: rtl/bcd_scan_display_decod.sv
// BCD to 7-segment decoder, active-low segments {g,f,e,d,c,b,a}.
module decodDisplay
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = 7'h40;
            4'd1: o_seg = 7'h79;
            4'd2: o_seg = 7'h24;
            4'd3: o_seg = 7'h30;
            4'd4: o_seg = 7'h19;
            4'd5: o_seg = 7'h12;
            4'd6: o_seg = 7'h02;
            4'd7: o_seg = 7'h78;
            4'd8: o_seg = 7'h00;
            4'd9: o_seg = 7'h10;
            default: o_seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_scan_display.sv
// Scans N BCD digits onto a shared segment bus with per-slot dead time and leading-zero blanking.
// Each slot's digit is frozen at slot start so a load never tears the digit on show.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 8,
    parameter int BLANK_LZ = 1
) (
    input logic               clk,
    input logic               rst_n,
    bcd_scan_display_if.slave bus
);
    localparam int PW = clog2(SCAN_DIV);
    localparam int IW = clog2(N_DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [4*N_DIGITS-1:0] r_digits, w_digits_next;
    logic [N_DIGITS-1:0]   r_dps, w_dps_next;
    logic [PW-1:0]         r_pre, w_pre_next;
    logic [IW-1:0]         r_idx, w_idx_next;
    logic                  w_wrap, w_in_dead;

    logic [3:0]            r_slot_digit, w_slot_digit_next;
    logic                  r_slot_dp, w_slot_dp_next;
    logic                  r_slot_lz, w_slot_lz_next;

    logic [3:0]            w_digit_arr [N_DIGITS];
    logic [N_DIGITS-1:0]   w_lz;
    logic [6:0]            w_seg;

    logic [N_DIGITS-1:0]   r_an, w_an_next;
    logic [6:0]            r_display, w_display_next;
    logic                  r_dp, w_dp_next;

    assign w_digits_next = bus.load ? bus.digits_in : r_digits;
    assign w_dps_next    = bus.load ? bus.dp_in     : r_dps;

    assign w_wrap     = (r_pre == PRE_LAST);
    assign w_pre_next = w_wrap ? '0 : r_pre + PW'(1);
    assign w_idx_next = !w_wrap ? r_idx : ((r_idx == IDX_LAST) ? '0 : r_idx + IW'(1));
    assign w_in_dead  = (int'(w_pre_next) < DEAD_CYC);

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign w_digit_arr[gi] = w_digits_next[4*gi +: 4];
        end
    endgenerate

    // Leading-zero mask: a digit blanks when it and everything above it is zero; digit 0 never blanks.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        w_lz       = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (w_digit_arr[k] == 4'd0);
            w_lz[k]    = (BLANK_LZ != 0) && (k != 0) && zero_above;
        end
    end

    // Slot contents are taken from the post-load shadow so a load on the slot-start edge is shown.
    assign w_slot_digit_next = w_wrap ? w_digit_arr[w_idx_next] : r_slot_digit;
    assign w_slot_dp_next    = w_wrap ? w_dps_next[w_idx_next]  : r_slot_dp;
    assign w_slot_lz_next    = w_wrap ? w_lz[w_idx_next]        : r_slot_lz;

    decodDisplay u_decod (
        .i_bcd (w_slot_digit_next),
        .o_seg (w_seg)
    );

    always_comb begin
        w_an_next      = '1;
        w_display_next = SEG_BLANK;
        w_dp_next      = 1'b0;
        if (!w_in_dead) begin
            w_an_next[w_idx_next] = 1'b0;
            if (bus.lamp_test) begin
                w_display_next = SEG_ALL;
                w_dp_next      = 1'b1;
            end else begin
                w_dp_next = w_slot_dp_next;
                if (w_slot_lz_next) begin
                    w_display_next = SEG_BLANK;
                end else if (w_slot_digit_next > 4'd9) begin
                    w_display_next = SEG_DASH;
                end else begin
                    w_display_next = w_seg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits     <= '0;
            r_dps        <= '0;
            r_pre        <= '0;
            r_idx        <= '0;
            r_slot_digit <= 4'd0;
            r_slot_dp    <= 1'b0;
            r_slot_lz    <= 1'b0;
            r_an         <= '1;
            r_display    <= SEG_BLANK;
            r_dp         <= 1'b0;
        end else begin
            r_digits     <= w_digits_next;
            r_dps        <= w_dps_next;
            r_pre        <= w_pre_next;
            r_idx        <= w_idx_next;
            r_slot_digit <= w_slot_digit_next;
            r_slot_dp    <= w_slot_dp_next;
            r_slot_lz    <= w_slot_lz_next;
            r_an         <= w_an_next;
            r_display    <= w_display_next;
            r_dp         <= w_dp_next;
        end
    end

    assign bus.an      = r_an;
    assign bus.display = r_display;
    assign bus.dp      = r_dp;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: per-cycle reference model, frame tables, corner sequences.
module tb_bcd_scan_display;
    localparam int N = 4;
    localparam int S = 6;
    localparam int D = 2;
    localparam int FRAME = S * N;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] ALL   = 7'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_scan_display_if #(.N_DIGITS(N)) bus ();

    bcd_scan_display #(
        .N_DIGITS (N),
        .SCAN_DIV (S),
        .DEAD_CYC (D),
        .BLANK_LZ (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference glyphs for 0..9, active low {g,f,e,d,c,b,a}.
    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [15:0]      dg;
        logic [3:0]       dpv;
        logic [3:0][6:0]  seg;
        logic [3:0]       dpe;
    } vec_t;
    vec_t vecs [4];

    int total = 0;
    int bad   = 0;
    int t     = 0;
    logic lamp_v = 1'b0;
    logic [3:0] m_dig  [N];
    logic       m_dp   [N];
    logic [3:0] s_dig  [N];
    logic       s_dp   [N];
    logic       m_lamp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_lamp = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_dig[k] = 4'd0; m_dp[k] = 1'b0; s_dig[k] = 4'd0; s_dp[k] = 1'b0;
        end
    endtask

    // Expected outputs from elapsed cycles since reset release and the digits frozen at slot start.
    task automatic expect_now(output logic [3:0] e_an, output logic [6:0] e_seg, output logic e_dp);
        int p, idx;
        bit lz;
        p = t % S;
        idx = (t / S) % N;
        e_an = 4'hF; e_seg = BLANK; e_dp = 1'b0;
        if (p >= D) begin
            e_an[idx] = 1'b0;
            lz = (idx != 0);
            for (int k = idx; k < N; k++) if (s_dig[k] != 4'd0) lz = 0;
            e_dp = s_dp[idx];
            if (m_lamp) begin
                e_seg = ALL; e_dp = 1'b1;
            end else if (lz) e_seg = BLANK;
            else if (s_dig[idx] > 4'd9) e_seg = DASH;
            else e_seg = glyph[s_dig[idx]];
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        expect_now(e_an, e_seg, e_dp);
        check({tag, "_an"}, 32'(bus.an), 32'(e_an));
        check({tag, "_seg"}, 32'(bus.display), 32'(e_seg));
        check({tag, "_dp"}, 32'(bus.dp), 32'(e_dp));
        check({tag, "_an_onehot0"}, 32'($countones(~bus.an) <= 1), 32'd1);
    endtask

    // One clock: drive at negedge, update model at posedge, compare at the following negedge.
    task automatic tick(input bit ld, input logic [15:0] dg, input logic [3:0] dpv, input bit lamp);
        bus.load = ld; bus.digits_in = dg; bus.dp_in = dpv; bus.lamp_test = lamp;
        @(posedge clk);
        t++;
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                m_dig[k] = dg[4*k +: 4]; m_dp[k] = dpv[k];
            end
        end
        m_lamp = lamp;
        if (t % S == 0) begin
            s_dig = m_dig; s_dp = m_dp;
        end
        @(negedge clk);
        check_outputs("scan");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0, lamp_v);
    endtask

    task automatic advance_to(input int frame_pos);
        while (t % FRAME != frame_pos) idle(1);
    endtask

    task automatic pulse_reset();
        bus.load = 1'b0; bus.lamp_test = 1'b0; lamp_v = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_an", 32'(bus.an), 32'hF);
        check("rst_async_seg", 32'(bus.display), 32'(BLANK));
        check("rst_async_dp", 32'(bus.dp), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs("post_rst");
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000};
        vecs[1] = '{16'h0070, 4'b1000, {BLANK, BLANK, 7'h78, 7'h40}, 4'b1000};
        vecs[2] = '{16'h0000, 4'b0000, {BLANK, BLANK, BLANK, 7'h40}, 4'b0000};
        vecs[3] = '{16'h9AF0, 4'b0101, {7'h10, DASH, DASH, 7'h40}, 4'b0101};

        bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.lamp_test = 1'b0;
        model_reset();

        // Reset held, then released: slot 0 enable at cycle 2, slot 1 enable at cycle 8.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_an", 32'(bus.an), 32'hF);
        check("hold_seg", 32'(bus.display), 32'(BLANK));
        check("hold_dp", 32'(bus.dp), 32'd0);
        rst_n = 1'b1;
        check_outputs("release");
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (t == 1) check("c1_an", 32'(bus.an), 32'hF);
            if (t == 2) check("c2_an", 32'(bus.an), 32'hE);
            if (t == 5) check("c5_an", 32'(bus.an), 32'hE);
            if (t == 6) check("c6_an", 32'(bus.an), 32'hF);
            if (t == 8) check("c8_an", 32'(bus.an), 32'hD);
        end

        // Frame tables: two full frames per loaded pattern, checked against hand-computed glyphs.
        for (int v = 0; v < 4; v++) begin
            tick(1'b1, vecs[v].dg, vecs[v].dpv, 1'b0);
            advance_to(0);
            for (int c = 0; c < 2 * FRAME; c++) begin
                idle(1);
                if (t % S == D) begin
                    check($sformatf("vec%0d_d%0d_seg", v, (t / S) % N), 32'(bus.display), 32'(vecs[v].seg[(t / S) % N]));
                    check($sformatf("vec%0d_d%0d_dp", v, (t / S) % N), 32'(bus.dp), 32'(vecs[v].dpe[(t / S) % N]));
                end
            end
        end

        // Lamp test mid-slot with 9AF0 still shown.
        advance_to(3);
        lamp_v = 1'b1;
        idle(1);
        check("lamp_seg", 32'(bus.display), 32'(ALL));
        check("lamp_dp", 32'(bus.dp), 32'd1);
        check("lamp_an", 32'(bus.an), 32'hE);
        idle(8);
        lamp_v = 1'b0;
        idle(1);
        check("lamp_off_seg", 32'(bus.display), 32'(((t % S) < D) ? BLANK : glyph[9]));

        // Load mid-slot of digit 1: no tearing, new value at digit 2 slot.
        tick(1'b1, 16'h1111, 4'h0, 1'b0);
        advance_to(0);
        advance_to(9);
        check("pre_load_seg", 32'(bus.display), 32'(glyph[1]));
        tick(1'b1, 16'h2222, 4'h0, 1'b0);
        while (t % FRAME != 11) begin
            check("no_tear_seg", 32'(bus.display), 32'(glyph[1]));
            idle(1);
        end
        check("no_tear_end_seg", 32'(bus.display), 32'(glyph[1]));
        advance_to(14);
        check("slot2_new_seg", 32'(bus.display), 32'(glyph[2]));
        check("slot2_new_an", 32'(bus.an), 32'hB);

        // Reset pulse mid-slot of digit 2: shadow cleared, scan restarts at digit 0.
        advance_to(15);
        pulse_reset();
        idle(1);
        check("rst_dead_an", 32'(bus.an), 32'hF);
        idle(1);
        check("rst_d0_an", 32'(bus.an), 32'hE);
        check("rst_d0_seg", 32'(bus.display), 32'(glyph[0]));
        advance_to(14);
        check("rst_d2_seg", 32'(bus.display), 32'(BLANK));

        // Random loads, digit mixes biased toward zeros, occasional lamp test.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] dg;
            for (int k = 0; k < N; k++)
                dg[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            lamp_v = ($urandom_range(0, 15) == 0);
            tick($urandom_range(0, 5) == 0, dg, 4'($urandom_range(0, 15)), lamp_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
